// File: rtl/clk_vga_pkg.sv
// -----------------------------------------------------------------------------
// clk_vga_pkg
// Shared constants for the 1024x768@60 video path and the helper that turns a
// frequency ratio into a phase-accumulator increment.
//   H_*   : horizontal timing in pixels (active / front porch / sync / back porch)
//   V_*   : vertical timing in lines
//   PIX_HZ: nominal pixel clock
//   calc_inc(): round(out_hz * 2^acc_w / in_hz), evaluated at elaboration
// -----------------------------------------------------------------------------
package clk_vga_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int H_TOTAL  = 1344;

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = 806;

    localparam int PIX_HZ   = 65_000_000;

    // Adding half the divisor before the integer divide gives round-to-nearest.
    function automatic longint unsigned calc_inc(
        input longint unsigned out_hz,
        input longint unsigned in_hz,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = out_hz << acc_w;
        return (num + (in_hz >> 1)) / in_hz;
    endfunction

endpackage

// File: rtl/phase_acc.sv
// -----------------------------------------------------------------------------
// phase_acc
// Free-running phase accumulator. The MSB is the synthesized clock; a
// registered pulse marks the cycle in which the MSB first reads 1.
// Ports:
//   i_clk    : sole clock
//   i_resetn : synchronous active-low reset (clears accumulator and pulse)
//   o_msb    : accumulator MSB, straight from the register
//   o_rise   : one-cycle pulse aligned with the MSB 0->1 transition
// -----------------------------------------------------------------------------
module phase_acc #(
    parameter int               ACC_W = 32,
    parameter logic [ACC_W-1:0] INC   = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic i_clk,
    input  logic i_resetn,
    output logic o_msb,
    output logic o_rise
);

    logic [ACC_W-1:0] r_acc;
    logic             r_rise;
    logic [ACC_W-1:0] w_acc_nxt;

    // Carry out of the top bit is dropped: the accumulator wraps modulo 2^ACC_W.
    assign w_acc_nxt = r_acc + INC;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_acc  <= '0;
            r_rise <= 1'b0;
        end else begin
            r_acc  <= w_acc_nxt;
            // Decided from the next value so the pulse lands in the same
            // cycle the MSB register first shows 1.
            r_rise <= w_acc_nxt[ACC_W-1] & ~r_acc[ACC_W-1];
        end
    end

    assign o_msb  = r_acc[ACC_W-1];
    assign o_rise = r_rise;

endmodule

// File: rtl/clk_vga_1024_768.sv
// -----------------------------------------------------------------------------
// clk_vga_1024_768
// Fractional clock synthesizer producing the 1024x768@60 pixel clock from a
// single input clock with a phase accumulator, plus a lock indicator.
// Ports:
//   clk_in1  : input clock (IN_HZ nominal)
//   resetn   : synchronous active-low reset
//   clk_out1 : generated clock, accumulator MSB, register-driven
//   ce_out   : one-cycle clk_in1-domain pulse on each clk_out1 rising transition
//   locked   : high LOCK_CYCLES cycles after reset release, sticky until reset
// -----------------------------------------------------------------------------
module clk_vga_1024_768
    import clk_vga_pkg::*;
#(
    parameter int IN_HZ       = 130_000_000,
    parameter int OUT_HZ      = 65_000_000,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 64
) (
    input  logic clk_in1,
    input  logic resetn,
    output logic clk_out1,
    output logic ce_out,
    output logic locked
);

    localparam longint unsigned INC_L =
        calc_inc(64'(OUT_HZ), 64'(IN_HZ), ACC_W);
    localparam logic [ACC_W-1:0] INC = ACC_W'(INC_L);

    localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    // Illegal configurations stop elaboration.
    if (64'(OUT_HZ) * 2 > 64'(IN_HZ)) begin : g_err_ratio
        $error("clk_vga_1024_768: OUT_HZ*2 must not exceed IN_HZ");
    end
    if (INC_L == 0) begin : g_err_inc
        $error("clk_vga_1024_768: increment rounds to zero");
    end
    if (ACC_W < 8) begin : g_err_accw
        $error("clk_vga_1024_768: ACC_W must be at least 8");
    end
    if (LOCK_CYCLES < 1) begin : g_err_lock
        $error("clk_vga_1024_768: LOCK_CYCLES must be at least 1");
    end
    if (H_ACTIVE + H_FP + H_SYNC + H_BP != H_TOTAL ||
        V_ACTIVE + V_FP + V_SYNC + V_BP != V_TOTAL) begin : g_err_timing
        $error("clk_vga_1024_768: video timing constants inconsistent");
    end

    logic             w_msb;
    logic             w_rise;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_locked;

    phase_acc #(
        .ACC_W (ACC_W),
        .INC   (INC)
    ) u_phase_acc (
        .i_clk    (clk_in1),
        .i_resetn (resetn),
        .o_msb    (w_msb),
        .o_rise   (w_rise)
    );

    // Lock counter saturates; locked is set on the edge the count reaches
    // LOCK_MAX and is only ever cleared by reset.
    always_ff @(posedge clk_in1) begin
        if (!resetn) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            if (r_lock_cnt != LOCK_MAX) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
            if (r_lock_cnt == LOCK_MAX - 1'b1) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign clk_out1 = w_msb;
    assign ce_out   = w_rise;
    assign locked   = r_locked;

endmodule

// File: tb/tb_clk_vga_1024_768.sv
module tb_clk_vga_1024_768;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic o0, c0, l0;   // defaults: 130 MHz -> 65 MHz
    logic o1, c1, l1;   // 100 MHz -> 25 MHz
    logic o2, c2, l2;   // 100 MHz -> 40 MHz

    always #5 clk = ~clk;

    clk_vga_1024_768 u_dut_def (
        .clk_in1  (clk),
        .resetn   (resetn),
        .clk_out1 (o0),
        .ce_out   (c0),
        .locked   (l0)
    );

    clk_vga_1024_768 #(
        .IN_HZ  (100_000_000),
        .OUT_HZ (25_000_000)
    ) u_dut_25 (
        .clk_in1  (clk),
        .resetn   (resetn),
        .clk_out1 (o1),
        .ce_out   (c1),
        .locked   (l1)
    );

    clk_vga_1024_768 #(
        .IN_HZ  (100_000_000),
        .OUT_HZ (40_000_000)
    ) u_dut_40 (
        .clk_in1  (clk),
        .resetn   (resetn),
        .clk_out1 (o2),
        .ce_out   (c2),
        .locked   (l2)
    );

    // Hand-computed increments: 2^31, 2^30, round(0.4 * 2^32).
    localparam longint unsigned INC0 = 64'd2147483648;
    localparam longint unsigned INC1 = 64'd1073741824;
    localparam longint unsigned INC2 = 64'd1717986918;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: number of released edges since the last reset edge.
    longint unsigned n_edges = 0;
    always @(posedge clk) begin
        if (!resetn) n_edges <= 0;
        else         n_edges <= n_edges + 1;
    end

    // Phase after n edges is n*INC mod 2^32; the output is its top bit.
    function automatic logic msb_at(input longint unsigned n, input longint unsigned inc);
        longint unsigned p;
        p = (n * inc) & 64'h0000_0000_FFFF_FFFF;
        return p[31];
    endfunction

    function automatic logic rise_at(input longint unsigned n, input longint unsigned inc);
        if (n == 0) return 1'b0;
        return msb_at(n, inc) && !msb_at(n - 1, inc);
    endfunction

    always @(negedge clk) begin
        chk("clk_out_def", {63'd0, o0}, {63'd0, msb_at(n_edges, INC0)});
        chk("ce_def",      {63'd0, c0}, {63'd0, rise_at(n_edges, INC0)});
        chk("locked_def",  {63'd0, l0}, {63'd0, n_edges >= 64});
        chk("clk_out_25",  {63'd0, o1}, {63'd0, msb_at(n_edges, INC1)});
        chk("ce_25",       {63'd0, c1}, {63'd0, rise_at(n_edges, INC1)});
        chk("locked_25",   {63'd0, l1}, {63'd0, n_edges >= 64});
        chk("clk_out_40",  {63'd0, o2}, {63'd0, msb_at(n_edges, INC2)});
        chk("ce_40",       {63'd0, c2}, {63'd0, rise_at(n_edges, INC2)});
        chk("locked_40",   {63'd0, l2}, {63'd0, n_edges >= 64});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce1, ce2, run1, run2, max2, min1, max1, trans1, lockbad;
        logic p1, p2;

        // Reset held for three edges.
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_clk_out", {63'd0, o0}, 64'd0);
        chk("rst_ce",      {63'd0, c0}, 64'd0);
        chk("rst_locked",  {63'd0, l0}, 64'd0);
        resetn = 1'b1;

        // Toggle pattern and lock timing after release.
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk("rel_clk_out", {63'd0, o0}, 64'(k % 2));
                chk("rel_ce",      {63'd0, c0}, 64'(k % 2));
            end
            if (k == 63) chk("locked_at_63", {63'd0, l0}, 64'd0);
            if (k == 64) chk("locked_at_64", {63'd0, l0}, 64'd1);
        end

        // Long window: frequency, phase lengths, locked holding.
        ce1 = 0; ce2 = 0; run1 = 1; run2 = 1; max2 = 0;
        min1 = 1000; max1 = 0; trans1 = 0; lockbad = 0;
        p1 = o1; p2 = o2;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            ce1 += int'(c1);
            ce2 += int'(c2);
            if (l0 !== 1'b1) lockbad++;
            if (o2 === p2) run2++;
            else begin
                if (run2 > max2) max2 = run2;
                run2 = 1;
            end
            if (o1 === p1) run1++;
            else begin
                trans1++;
                if (trans1 > 1) begin
                    if (run1 < min1) min1 = run1;
                    if (run1 > max1) max1 = run1;
                end
                run1 = 1;
            end
            p1 = o1; p2 = o2;
        end
        chk("ce25_count",      64'(ce1), 64'd2500);
        chk("ce40_count_ok",   64'(ce2 >= 3999 && ce2 <= 4001), 64'd1);
        chk("phase40_max_le2", 64'(max2 <= 2), 64'd1);
        chk("phase25_min",     64'(min1), 64'd2);
        chk("phase25_max",     64'(max1), 64'd2);
        chk("locked_held",     64'(lockbad), 64'd0);

        // Mid-run reset with MSB high and locked.
        for (int t = 0; t < 4 && o0 !== 1'b1; t++) @(negedge clk);
        chk("pre_rst_msb",    {63'd0, o0}, 64'd1);
        chk("pre_rst_locked", {63'd0, l0}, 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_clk_out", {63'd0, o0}, 64'd0);
        chk("mid_rst_ce",      {63'd0, c0}, 64'd0);
        chk("mid_rst_locked",  {63'd0, l0}, 64'd0);
        resetn = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 63) chk("relock_at_63", {63'd0, l0}, 64'd0);
            if (k == 64) chk("relock_at_64", {63'd0, l0}, 64'd1);
        end

        // Random reset pulses at arbitrary phases; the model checks every cycle.
        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            resetn = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            resetn = 1'b1;
        end
        repeat (100) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/clk_vga_1024_768.md
CLK_VGA_1024_768 -- requirements
Module: clk_vga_1024_768

Interface
REQ-001 Parameter IN_HZ, default 130_000_000, nominal frequency of clk_in1 in Hz.
REQ-002 Parameter OUT_HZ, default 65_000_000, target average frequency of clk_out1 in Hz (1024x768@60 pixel clock).
REQ-003 Parameter ACC_W, default 32, phase-accumulator width in bits.
REQ-004 Parameter LOCK_CYCLES, default 64, number of clk_in1 cycles after reset release before locked asserts.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk_in1  input  1  sole clock; all state updates on its rising edge.
REQ-007 resetn  input  1  synchronous active-low reset.
REQ-008 clk_out1  output  1  generated pixel clock, the accumulator MSB, driven directly from a register.
REQ-009 ce_out  output  1  one-cycle pulse, clk_in1 domain, marking each clk_out1 rising transition.
REQ-010 locked  output  1  high once clk_out1 is stable; stays high until the next reset.

Function
REQ-011 Increment INC SHALL be an elaboration-time constant: round(OUT_HZ * 2^ACC_W / IN_HZ).
REQ-012 Elaboration SHALL fail with an error if OUT_HZ*2 > IN_HZ, if INC == 0, or if ACC_W < 8.
REQ-013 With resetn high, each clk_in1 edge: acc <= acc + INC, modulo 2^ACC_W (wrap-around silently discards the carry).
REQ-014 clk_out1 SHALL equal acc[ACC_W-1]; no combinational logic between the register and the port.
REQ-015 ce_out SHALL be high for exactly the one clk_in1 cycle in which acc[ACC_W-1] changed 0->1 on the preceding edge; it is high in the same cycle clk_out1 first reads 1.
REQ-016 Average clk_out1 frequency SHALL equal IN_HZ*INC/2^ACC_W; per-period jitter SHALL be at most one clk_in1 period.
REQ-017 Lock counter SHALL count clk_in1 cycles from reset release, saturating at LOCK_CYCLES.
REQ-018 locked SHALL rise on the edge at which the lock counter reaches LOCK_CYCLES and SHALL never deassert except by reset.
REQ-019 clk_out1 SHALL toggle from the first edge after reset release, independent of locked.
REQ-020 With the defaults, INC = 2^31, so clk_out1 toggles every clk_in1 cycle: exact 65 MHz, 50% duty cycle.

Reset
REQ-021 While resetn is low at a clk_in1 edge: acc <= 0, clk_out1 = 0, ce_out = 0, lock counter <= 0, locked = 0.
REQ-022 Reset asserted mid-operation SHALL take effect at the next edge regardless of the phase of acc; no partial clk_out1 pulse beyond that edge.
REQ-023 The first edge with resetn high SHALL load acc with INC.

Structure
REQ-024 Shared package clk_vga_pkg SHALL hold the 1024x768 timing constants: H 1024/24/136/160, total 1344; V 768/3/6/29, total 806; PIX_HZ = 65_000_000.
REQ-025 The package SHALL also hold the INC computation function.
REQ-026 One sub-module is natural: phase_acc (accumulator, MSB output, rise-detect pulse).
REQ-027 The lock counter and parameter checks SHALL reside in the top module.

Verification
REQ-028 Defaults; resetn low for 3 cycles, then high -> clk_out1 = 0 during reset; 1,0,1,0,... from the first released edge; ce_out on every second cycle.
REQ-029 Defaults; count 64 cycles after release -> locked = 0 through cycle 63, 1 at cycle 64; it remains 1 for 10000 further cycles.
REQ-030 IN_HZ = 100_000_000, OUT_HZ = 25_000_000 -> INC = 2^30; clk_out1 period exactly 4 cycles (2 high, 2 low); one ce_out per period.
REQ-031 IN_HZ = 100_000_000, OUT_HZ = 40_000_000 -> exactly 40000 ce_out pulses in 100000 cycles (+/-1); no high or low phase longer than 2 cycles.
REQ-032 Reset pulse mid-run, with acc MSB = 1 and locked = 1 -> next edge: clk_out1 = 0, ce_out = 0, locked = 0; locked re-asserts 64 cycles after release.
REQ-033 OUT_HZ = 70_000_000 with IN_HZ = 130_000_000 -> elaboration error.
